// File: rtl/seg_pattern_decoder_if.sv
// Segment-stream in, packed hex-word out, with abort and the partial-digit count.
// The slave side is the decoder; the master side drives digits and consumes words.
interface seg_pattern_decoder_if #(
  parameter int NIBBLES = 4
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  logic [6:0]    seg_in;
  logic          seg_valid;
  logic          seg_ready;
  logic          abort;
  logic [W-1:0]  word_out;
  logic          word_err;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] count;

  modport slave (
    input  seg_in, seg_valid, abort, word_ready,
    output seg_ready, word_out, word_err, word_valid, count
  );

  modport master (
    output seg_in, seg_valid, abort, word_ready,
    input  seg_ready, word_out, word_err, word_valid, count
  );
endinterface

// File: rtl/seg_pattern_decoder.sv
// Decodes active-low 7-segment patterns to hex and packs NIBBLES digits per word.
// Word valid 1 cycle after the last digit; only the completing digit stalls on a full output.
module seg_pattern_decoder #(
  parameter int NIBBLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  seg_pattern_decoder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  logic [W-5:0]  shift_q;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic [W-1:0]  word_q;
  logic          word_err_q;
  logic          word_vld_q;

  logic [3:0]    digit;
  logic          illegal;
  logic          seg_rdy;
  logic          accept;
  logic          complete;
  logic [W-1:0]  next_word;

  always_comb begin
    digit   = 4'h0;
    illegal = 1'b0;
    case (bus.seg_in)
      7'b1000000: digit = 4'h0;
      7'b1111001: digit = 4'h1;
      7'b0100100: digit = 4'h2;
      7'b0110000: digit = 4'h3;
      7'b0011001: digit = 4'h4;
      7'b0010010: digit = 4'h5;
      7'b0000010: digit = 4'h6;
      7'b1111000: digit = 4'h7;
      7'b0000000: digit = 4'h8;
      7'b0010000: digit = 4'h9;
      7'b0001000: digit = 4'hA;
      7'b0000011: digit = 4'hB;
      7'b0100111: digit = 4'hC;
      7'b0100001: digit = 4'hD;
      7'b0000110: digit = 4'hE;
      7'b0001110: digit = 4'hF;
      default:    illegal = 1'b1;
    endcase
  end

  // Only the completing digit needs the output register to be free (or freeing).
  assign seg_rdy   = rst_n & ((count_q != LAST) | ~word_vld_q | bus.word_ready);
  assign accept    = bus.seg_valid & seg_rdy;
  assign complete  = accept & ~bus.abort & (count_q == LAST);
  assign next_word = {shift_q, digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.abort || complete) begin
      shift_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      shift_q <= next_word[W-5:0];
      count_q <= count_q + CW'(1);
      err_q   <= err_q | illegal;
    end
  end

  // A completion on the handshake edge reloads in place, so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      word_err_q <= 1'b0;
      word_vld_q <= 1'b0;
    end else if (complete) begin
      word_q     <= next_word;
      word_err_q <= err_q | illegal;
      word_vld_q <= 1'b1;
    end else if (word_vld_q && bus.word_ready) begin
      word_vld_q <= 1'b0;
    end
  end

  assign bus.seg_ready  = seg_rdy;
  assign bus.word_out   = word_q;
  assign bus.word_err   = word_err_q;
  assign bus.word_valid = word_vld_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder with NIBBLES=4 (16-bit words).
module tb_seg_pattern_decoder;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [6:0] tab [16];

  seg_pattern_decoder_if #(.NIBBLES(4)) bus ();

  seg_pattern_decoder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    bus.seg_valid = 1'b1;
    bus.seg_in    = tab[d];
    tick();
  endtask

  task automatic idle();
    bus.seg_valid = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.seg_in     = 7'h00;
    bus.word_ready = 1'b1;
    tick();
    tick();
    tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.word_valid); end
    tests++; if (bus.word_out !== 16'h0) begin fails++; $display("FAIL reset_word: got %h want 0000", bus.word_out); end
    tests++; if (bus.word_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.word_err); end
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tests++; if (bus.seg_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.seg_ready); end
    rst_n = 1'b1;
    tick();
    tests++; if (bus.seg_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", bus.seg_ready); end
  endtask

  task automatic test_basic();
    bus.word_ready = 1'b1;
    bus.seg_valid  = 1'b0;
    bus.seg_in     = tab[9];
    tick();
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL ignore_invalid: count %0d want 0", bus.count); end
    push(1);
    push(2);
    tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL basic_count: got %0d want 2", bus.count); end
    push(3);
    tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL basic_early: valid %b want 0", bus.word_valid); end
    push(4);
    idle();
    tests++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", bus.word_valid); end
    tests++; if (bus.word_out !== 16'h1234) begin fails++; $display("FAIL basic_word: got %h want 1234", bus.word_out); end
    tests++; if (bus.word_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", bus.word_err); end
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL basic_count_clr: got %0d want 0", bus.count); end
    tick();
    tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse: valid %b want 0", bus.word_valid); end
    tests++; if (bus.word_out !== 16'h1234) begin fails++; $display("FAIL basic_hold: got %h want 1234", bus.word_out); end
  endtask

  task automatic test_error();
    bus.word_ready = 1'b1;
    push(10);
    push(11);
    bus.seg_valid = 1'b1;
    bus.seg_in    = 7'b1111111;
    tick();
    push(15);
    idle();
    tests++; if (bus.word_out !== 16'hAB0F) begin fails++; $display("FAIL err_word: got %h want ab0f", bus.word_out); end
    tests++; if (bus.word_err !== 1'b1) begin fails++; $display("FAIL err_flag: got %b want 1", bus.word_err); end
    tick();
    push(5);
    push(6);
    push(7);
    push(8);
    idle();
    tests++; if (bus.word_out !== 16'h5678) begin fails++; $display("FAIL clean_word: got %h want 5678", bus.word_out); end
    tests++; if (bus.word_err !== 1'b0) begin fails++; $display("FAIL clean_err: got %b want 0", bus.word_err); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.word_ready = 1'b0;
    push(9);
    push(8);
    push(7);
    push(6);
    tests++; if (bus.word_out !== 16'h9876) begin fails++; $display("FAIL bp_first: got %h want 9876", bus.word_out); end
    push(5);
    push(4);
    push(3);
    tests++; if (bus.count !== 3'd3) begin fails++; $display("FAIL bp_count: got %0d want 3", bus.count); end
    tests++; if (bus.word_out !== 16'h9876 || bus.word_valid !== 1'b1) begin fails++; $display("FAIL bp_hold: got %h/%b want 9876/1", bus.word_out, bus.word_valid); end
    bus.seg_valid = 1'b1;
    bus.seg_in    = tab[2];
    #1;
    tests++; if (bus.seg_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: ready %b want 0", bus.seg_ready); end
    tick();
    tests++; if (bus.count !== 3'd3 || bus.word_out !== 16'h9876) begin fails++; $display("FAIL bp_no_accept: count %0d word %h want 3/9876", bus.count, bus.word_out); end
    bus.word_ready = 1'b1;
    #1;
    tests++; if (bus.seg_ready !== 1'b1) begin fails++; $display("FAIL bp_release: ready %b want 1", bus.seg_ready); end
    tick();
    idle();
    tests++; if (bus.word_out !== 16'h5432 || bus.word_valid !== 1'b1) begin fails++; $display("FAIL bp_second: got %h/%b want 5432/1", bus.word_out, bus.word_valid); end
    tick();
    tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: valid %b want 0", bus.word_valid); end
  endtask

  task automatic test_back_to_back();
    bus.word_ready = 1'b0;
    push(1);
    push(2);
    push(3);
    push(4);
    push(5);
    push(6);
    push(7);
    bus.seg_valid  = 1'b1;
    bus.seg_in     = tab[8];
    bus.word_ready = 1'b1;
    #1;
    tests++; if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h1234) begin fails++; $display("FAIL b2b_first: got %h/%b want 1234/1", bus.word_out, bus.word_valid); end
    tick();
    idle();
    tests++; if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h5678) begin fails++; $display("FAIL b2b_second: got %h/%b want 5678/1", bus.word_out, bus.word_valid); end
    tick();
    tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: valid %b want 0", bus.word_valid); end
  endtask

  task automatic test_abort();
    bus.word_ready = 1'b0;
    push(12);
    push(13);
    push(14);
    push(15);
    push(1);
    push(2);
    tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL abort_pre: count %0d want 2", bus.count); end
    bus.seg_valid = 1'b1;
    bus.seg_in    = tab[3];
    bus.abort     = 1'b1;
    #1;
    tests++; if (bus.seg_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", bus.seg_ready); end
    tick();
    bus.abort = 1'b0;
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL abort_count: got %0d want 0", bus.count); end
    tests++; if (bus.word_out !== 16'hCDEF || bus.word_valid !== 1'b1) begin fails++; $display("FAIL abort_held: got %h/%b want cdef/1", bus.word_out, bus.word_valid); end
    push(4);
    push(5);
    push(6);
    bus.seg_valid  = 1'b1;
    bus.seg_in     = tab[7];
    bus.word_ready = 1'b1;
    tick();
    idle();
    tests++; if (bus.word_out !== 16'h4567 || bus.word_err !== 1'b0) begin fails++; $display("FAIL abort_next: got %h/%b want 4567/0", bus.word_out, bus.word_err); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.word_ready = 1'b0;
    push(1);
    push(2);
    push(3);
    push(4);
    push(5);
    tests++; if (bus.word_valid !== 1'b1 || bus.count !== 3'd1) begin fails++; $display("FAIL arst_pre: valid %b count %0d want 1/1", bus.word_valid, bus.count); end
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b want 0", bus.word_valid); end
    tests++; if (bus.word_out !== 16'h0) begin fails++; $display("FAIL arst_word: got %h want 0000", bus.word_out); end
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL arst_count: got %0d want 0", bus.count); end
    tests++; if (bus.seg_ready !== 1'b0) begin fails++; $display("FAIL arst_ready: got %b want 0", bus.seg_ready); end
    idle();
    #2;
    rst_n = 1'b1;
    tick();
    tests++; if (bus.word_valid !== 1'b0 || bus.count !== 3'd0) begin fails++; $display("FAIL arst_after: valid %b count %0d want 0/0", bus.word_valid, bus.count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tab[0]  = 7'b1000000; tab[1]  = 7'b1111001; tab[2]  = 7'b0100100; tab[3]  = 7'b0110000;
    tab[4]  = 7'b0011001; tab[5]  = 7'b0010010; tab[6]  = 7'b0000010; tab[7]  = 7'b1111000;
    tab[8]  = 7'b0000000; tab[9]  = 7'b0010000; tab[10] = 7'b0001000; tab[11] = 7'b0000011;
    tab[12] = 7'b0100111; tab[13] = 7'b0100001; tab[14] = 7'b0000110; tab[15] = 7'b0001110;
    rst_n          = 1'b0;
    bus.seg_in     = 7'h00;
    bus.seg_valid  = 1'b0;
    bus.abort      = 1'b0;
    bus.word_ready = 1'b0;
    test_reset();
    test_basic();
    test_error();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_pattern_decoder.md
Name: seg_pattern_decoder

Overview:
- Receive side of the 7-segment display encoding: accepts a stream of active-low 7-segment patterns and decodes each back to its 4-bit hex value.
- Packs NIBBLES consecutive digits into one word and hands it on with a valid/ready handshake.
- Used for loopback checking of display paths and for capturing digits from segment-encoded test streams on the DE1 lab designs.

Parameters:
NIBBLES, 4, digits per output word (>=2); output width is 4*NIBBLES.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
seg_in  input  7  segment pattern, bit6..bit0 = g f e d c b a, active-low (0 = segment lit)
seg_valid  input  1  seg_in is valid this cycle
seg_ready  output  1  block accepts seg_in this cycle
abort  input  1  synchronous clear of the partial word in collection
word_out  output  4*NIBBLES  assembled word; first-received digit in the most significant nibble
word_err  output  1  at least one digit of word_out was an illegal pattern
word_valid  output  1  word_out/word_err valid
word_ready  input  1  downstream accepts the word
count  output  clog2(NIBBLES+1)  digits held in the partial word

Behaviour:
- One clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: shift register 0, count 0, partial error flag 0, word_out 0, word_err 0, word_valid 0.
- While reset is asserted, seg_ready is 0.
- Decode table (seg_in to value):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 0100111=c, 0100001=d, 0000110=E, 0001110=F
- Any other pattern is illegal: it decodes to 0 and sets the partial error flag.
- Decode is combinational. No latency is added before the shift.
- Accept: a digit is accepted when seg_valid && seg_ready.
  - Shift register becomes {shift[4N-5:0], digit}.
  - count increments.
  - Error flag ORs in the illegal indication.
- seg_ready = (count != NIBBLES-1) || !word_valid || word_ready.
  - This is combinational from word_valid/word_ready.
  - The first NIBBLES-1 digits can always be collected while an earlier word waits downstream.
  - Only the completing digit needs the output register free.
- Completion: when an accept occurs with count == NIBBLES-1:
  - Next cycle word_out = {shift[4N-5:0], digit}, word_err = flag | illegal(digit), word_valid = 1.
  - Shift register, count and flag clear to 0 in the same edge.
  - Latency from last digit accept to word_valid is 1 cycle.
- Output register:
  - Holds word_out/word_err/word_valid stable until word_valid && word_ready.
  - On that edge word_valid drops to 0, unless a completion occurs in the same cycle; then the new word loads and word_valid stays 1 (back-to-back, no bubble).
  - word_out keeps its last value when word_valid is 0.
- abort:
  - Clears shift, count and flag on the next edge and overrides any same-cycle accept; the digit is dropped.
  - Does not affect the output register or a pending word.
  - seg_ready is unaffected by abort.
- Reset mid-operation discards the partial word and any pending output word immediately.
- seg_in changes while seg_valid=0 are ignored.
- count never exceeds NIBBLES-1 at a clock edge.

Test Plan:
- Reset, word_ready=1, send 1111001, 0100100, 0110000, 0011001 on consecutive cycles -> one cycle after the 4th accept: word_out=16'h1234, word_err=0, word_valid=1 for exactly 1 cycle.
- Send 0001000, 0000011, 1111111, 0001110 -> word_out=16'hAB0F, word_err=1; the next clean word has word_err=0.
- word_ready=0, stream 8 digits -> first word held stable; digits 5-7 accepted (count=3); seg_ready=0 with 8th digit presented; raise word_ready -> 8th accepted that cycle, second word valid next cycle.
- Two words back-to-back with word_ready=1 -> word_valid stays high 2 consecutive cycles with different word_out values.
- Send 2 digits, pulse abort together with a 3rd valid digit -> count=0; the next 4 digits form the word alone; a held output word is untouched.
- Assert rst_n=0 asynchronously mid-word with word_valid=1 -> word_valid, word_out, count go 0 without waiting for a clock edge.
